// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // Index of the set bit in a one-hot (or zero) vector of up to 8 bits.
    function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = idx | (oh[i] ? 3'(i) : 3'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_winner,
    output logic             o_valid
);

    logic w_found;

    // Walk the requesters from the pointer, taking the first one that is asserted.
    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            o_winner[(int'(i_ptr) + k) % N_REQ] = !w_found && i_req[(int'(i_ptr) + k) % N_REQ];
            w_found = w_found | i_req[(int'(i_ptr) + k) % N_REQ];
        end
        o_valid = |i_req;
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Locks a UART transmitter to one byte-stream requester per message, round-robin,
// with a stall timeout that abandons a silent owner.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              i_req,
    input  logic [N_REQ-1:0][BYTE_W-1:0]  i_data,
    input  logic [N_REQ-1:0]              i_last,
    output logic [N_REQ-1:0]              o_cts,
    output logic [N_REQ-1:0]              o_idle,
    output logic [N_REQ-1:0]              o_grant,
    output logic                          o_abort,
    input  logic                          i_tx_cts,
    input  logic                          i_tx_idle,
    output logic [BYTE_W-1:0]             o_tx_data,
    output logic                          o_tx_req
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t        r_state;
    logic [N_REQ-1:0]  r_grant;
    logic [PW-1:0]     r_rr_ptr;
    logic [CW-1:0]     r_stall;
    logic              r_abort;

    logic [N_REQ-1:0]  w_winner;
    logic              w_any;
    logic              w_in_lock;
    logic              w_owner_req;
    logic              w_owner_last;
    logic [7:0]        w_grant8;
    logic [PW-1:0]     w_owner_idx;
    logic [PW-1:0]     w_ptr_next;
    logic [CW-1:0]     w_stall_next;
    logic [BYTE_W-1:0] w_data;

    rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_rr_pick (
        .i_req    (i_req),
        .i_ptr    (r_rr_ptr),
        .o_winner (w_winner),
        .o_valid  (w_any)
    );

    // Owner-side views and the pointer value that follows a release.
    always_comb begin
        w_grant8               = 8'd0;
        w_grant8[N_REQ-1:0]    = r_grant;
        w_owner_idx            = PW'(oh_to_idx(w_grant8));
        w_ptr_next             = (int'(w_owner_idx) == N_REQ - 1) ? '0 : w_owner_idx + PW'(1);
        w_owner_req            = |(i_req & r_grant);
        w_owner_last           = |(i_last & r_grant);
        w_stall_next           = r_stall + CW'(1);
        w_in_lock              = rst_n && (r_state == LOCK);
        w_data                 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_data = w_data | (r_grant[i] ? i_data[i] : {BYTE_W{1'b0}});
        end
    end

    // Forwarding is live only while locked; gating on rst_n keeps outputs quiet in reset.
    always_comb begin
        o_tx_req  = w_in_lock & w_owner_req;
        o_tx_data = w_in_lock ? w_data : {BYTE_W{1'b0}};
        o_cts     = w_in_lock ? (r_grant & i_req & {N_REQ{i_tx_cts}}) : {N_REQ{1'b0}};
        o_idle    = w_in_lock ? (r_grant & {N_REQ{i_tx_idle}}) : {N_REQ{1'b0}};
    end

    // Arbitration FSM; a transfer always clears the stall count, so last-byte beats timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_stall  <= '0;
            r_abort  <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any && i_tx_idle) begin
                        r_grant <= w_winner;
                        r_stall <= '0;
                        r_state <= LOCK;
                    end else begin
                        r_grant <= '0;
                    end
                end
                LOCK: begin
                    if (w_owner_req) begin
                        r_stall <= '0;
                        if (i_tx_cts && w_owner_last) begin
                            r_state <= DRAIN;
                        end else begin
                            r_state <= LOCK;
                        end
                    end else if (w_stall_next == CW'(TIMEOUT)) begin
                        r_abort  <= 1'b1;
                        r_grant  <= '0;
                        r_stall  <= '0;
                        r_rr_ptr <= w_ptr_next;
                        r_state  <= IDLE;
                    end else begin
                        r_stall <= w_stall_next;
                    end
                end
                DRAIN: begin
                    if (i_tx_idle) begin
                        r_grant  <= '0;
                        r_rr_ptr <= w_ptr_next;
                        r_state  <= IDLE;
                    end else begin
                        r_state <= DRAIN;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_stall <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_grant = r_grant;
    assign o_abort = r_abort;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb (N_REQ=4, TIMEOUT=4).
module tb_uart_tx_arb;

    logic             clk;
    logic             rst_n;
    logic [3:0]       i_req;
    logic [3:0][7:0]  i_data;
    logic [3:0]       i_last;
    logic [3:0]       o_cts;
    logic [3:0]       o_idle;
    logic [3:0]       o_grant;
    logic             o_abort;
    logic             i_tx_cts;
    logic             i_tx_idle;
    logic [7:0]       o_tx_data;
    logic             o_tx_req;

    int checks   = 0;
    int failures = 0;
    int cnt;

    uart_tx_arb #(.N_REQ(4), .TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_data    (i_data),
        .i_last    (i_last),
        .o_cts     (o_cts),
        .o_idle    (o_idle),
        .o_grant   (o_grant),
        .o_abort   (o_abort),
        .i_tx_cts  (i_tx_cts),
        .i_tx_idle (i_tx_idle),
        .o_tx_data (o_tx_data),
        .o_tx_req  (o_tx_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        i_req     = 4'b0000;
        i_data    = '0;
        i_last    = 4'b0000;
        i_tx_cts  = 1'b1;
        i_tx_idle = 1'b1;

        // Reset state, with requests present to show outputs stay quiet.
        cyc();
        i_req = 4'b1111;
        cyc();
        #1;
        chk("rst_grant", 32'(o_grant), 32'h0);
        chk("rst_abort", 32'(o_abort), 32'h0);
        chk("rst_cts", 32'(o_cts), 32'h0);
        chk("rst_idle", 32'(o_idle), 32'h0);
        chk("rst_txreq", 32'(o_tx_req), 32'h0);
        chk("rst_txdata", 32'(o_tx_data), 32'h0);
        chk("rst_ptr", 32'(dut.r_rr_ptr), 32'h0);

        // Single requester 2, seven bytes.
        i_req = 4'b0100;
        i_data[2] = 8'hA0;
        rst_n = 1'b1;
        #1;
        chk("single_pre_grant", 32'(o_grant), 32'h0);
        chk("single_pre_cts", 32'(o_cts), 32'h0);
        cyc();
        chk("single_grant", 32'(o_grant), 32'h4);
        cnt = 0;
        for (int b = 0; b < 7; b++) begin
            i_data[2] = 8'hA0 + 8'(b);
            i_last    = (b == 6) ? 4'b0100 : 4'b0000;
            #1;
            if (o_cts == 4'b0100) cnt++;
            chk("single_txdata", 32'(o_tx_data), 32'hA0 + 32'(b));
            chk("single_idle", 32'(o_idle), 32'h4);
            cyc();
        end
        chk("single_cts_count", 32'(cnt), 32'd7);
        i_req = 4'b0000;
        i_last = 4'b0000;
        i_tx_idle = 1'b0;
        #1;
        chk("drain_grant", 32'(o_grant), 32'h4);
        chk("drain_cts", 32'(o_cts), 32'h0);
        chk("drain_txreq", 32'(o_tx_req), 32'h0);
        cyc();
        chk("drain_hold", 32'(o_grant), 32'h4);
        i_tx_idle = 1'b1;
        cyc();
        chk("drain_release", 32'(o_grant), 32'h0);
        chk("single_ptr", 32'(dut.r_rr_ptr), 32'h3);

        // Contention from reset: 0 first, then 3, pointer wraps to 0.
        rst_n = 1'b0;
        i_req = 4'b1001;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("cont_grant0", 32'(o_grant), 32'h1);
        i_last = 4'b1001;
        #1;
        chk("cont_cts0", 32'(o_cts), 32'h1);
        cyc();
        cyc();
        chk("cont_rel0", 32'(o_grant), 32'h0);
        chk("cont_ptr1", 32'(dut.r_rr_ptr), 32'h1);
        cyc();
        chk("cont_grant3", 32'(o_grant), 32'h8);
        #1;
        chk("cont_cts3", 32'(o_cts), 32'h8);
        cyc();
        i_req = 4'b0000;
        i_last = 4'b0000;
        cyc();
        chk("cont_rel3", 32'(o_grant), 32'h0);
        chk("cont_ptr_wrap", 32'(dut.r_rr_ptr), 32'h0);

        // Timeout: owner 1 sends two bytes then goes silent.
        i_req = 4'b0010;
        i_data[1] = 8'h11;
        cyc();
        chk("to_grant", 32'(o_grant), 32'h2);
        cyc();
        cyc();
        i_req = 4'b0000;
        cyc();
        cyc();
        cyc();
        chk("to_no_abort_yet", 32'(o_abort), 32'h0);
        chk("to_grant_held", 32'(o_grant), 32'h2);
        cyc();
        chk("to_abort", 32'(o_abort), 32'h1);
        chk("to_grant_clr", 32'(o_grant), 32'h0);
        cyc();
        chk("to_abort_pulse", 32'(o_abort), 32'h0);
        chk("to_ptr", 32'(dut.r_rr_ptr), 32'h2);

        // Backpressure: tx_cts low 10 cycles with req[0] held.
        i_req = 4'b0001;
        i_data[0] = 8'h5A;
        i_tx_cts = 1'b0;
        cyc();
        chk("bp_grant", 32'(o_grant), 32'h1);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (o_cts != 4'b0000 || o_abort != 1'b0) cnt++;
            cyc();
        end
        chk("bp_quiet", 32'(cnt), 32'd0);
        i_tx_cts = 1'b1;
        i_last = 4'b0001;
        #1;
        chk("bp_cts", 32'(o_cts), 32'h1);
        chk("bp_data", 32'(o_tx_data), 32'h5A);
        cyc();
        i_req = 4'b0000;
        i_last = 4'b0000;
        cyc();
        chk("bp_ptr", 32'(dut.r_rr_ptr), 32'h1);

        // Mid-message reset during byte 3 of requester 1.
        i_req = 4'b0010;
        i_data[1] = 8'h33;
        cyc();
        chk("mr_grant", 32'(o_grant), 32'h2);
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        chk("mr_cts", 32'(o_cts), 32'h0);
        chk("mr_txreq", 32'(o_tx_req), 32'h0);
        chk("mr_txdata", 32'(o_tx_data), 32'h0);
        chk("mr_idle", 32'(o_idle), 32'h0);
        cyc();
        chk("mr_grant_clr", 32'(o_grant), 32'h0);
        chk("mr_abort", 32'(o_abort), 32'h0);
        cyc();
        chk("mr_abort2", 32'(o_abort), 32'h0);
        chk("mr_ptr", 32'(dut.r_rr_ptr), 32'h0);
        rst_n = 1'b1;
        i_req = 4'b0011;
        cyc();
        chk("mr_rearb", 32'(o_grant), 32'h1);
        i_last = 4'b0001;
        cyc();
        i_req = 4'b0000;
        i_last = 4'b0000;
        cyc();

        // Idle gating: no grant while the line is busy.
        i_req = 4'b0001;
        i_tx_idle = 1'b0;
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            if (o_grant != 4'b0000) cnt++;
        end
        chk("gate_no_grant", 32'(cnt), 32'd0);
        i_tx_idle = 1'b1;
        cyc();
        chk("gate_grant", 32'(o_grant), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of byte-stream requesters, range 2..8.
REQ-002 Parameter TIMEOUT, default 255: stall cycles before a lock is abandoned, range 1..255.
REQ-003 Ports: one clock; reset is synchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
REQ-004 Requester-side ports:
- i_req  in  N_REQ  per-requester byte valid.
- i_data  in  N_REQ x 8  per-requester byte.
- i_last  in  N_REQ  byte is final of message.
- o_cts  out  N_REQ  byte accepted this cycle.
- o_idle  out  N_REQ  granted and transmitter idle.
- o_grant  out  N_REQ  one-hot current owner, zero when unowned.
- o_abort  out  1  one-cycle pulse on timeout release.
REQ-005 Transmitter-side ports:
- i_tx_cts  in  1  transmitter accepts byte.
- i_tx_idle  in  1  transmitter line idle.
- o_tx_data  out  8  forwarded byte.
- o_tx_req  out  1  forwarded valid.

Function
REQ-006 FSM states SHALL be IDLE, LOCK and DRAIN.
REQ-007 IDLE: when any i_req is high and i_tx_idle is high, the block SHALL register a round-robin winner into o_grant and enter LOCK on the next edge.
REQ-008 Round-robin search SHALL start at index rr_ptr and wrap modulo N_REQ.
REQ-009 rr_ptr SHALL become the released owner's index + 1, wrapping modulo N_REQ, on every release (normal or abort).
REQ-010 LOCK, combinational forwarding for owner g:
- o_tx_req = i_req[g].
- o_tx_data = i_data[g].
- o_cts[g] = i_tx_cts & i_req[g].
- o_idle[g] = i_tx_idle.
- All other o_cts and o_idle SHALL be 0.
REQ-011 Outside LOCK: o_tx_req, o_cts and o_idle SHALL be 0; o_tx_data SHALL be 0.
REQ-012 LOCK: a byte is transferred when i_req[g] & i_tx_cts; a transfer with i_last[g] high SHALL move the FSM to DRAIN.
REQ-013 LOCK: stall counter SHALL increment each cycle i_req[g] is low and clear on any cycle i_req[g] is high.
REQ-014 Abort: on the cycle the stall count reaches TIMEOUT, the block SHALL pulse o_abort for one cycle, clear o_grant and go to IDLE without passing through DRAIN.
REQ-015 DRAIN: o_grant SHALL be held; the FSM SHALL return to IDLE on the first cycle i_tx_idle is high, then clear o_grant.
REQ-016 Requests from non-owners SHALL be ignored until the FSM returns to IDLE; a new arbitration SHALL NOT occur in the same cycle as a release.
REQ-017 Simultaneous last-byte transfer and TIMEOUT cannot coexist, because a transfer clears the stall count; the transfer SHALL win.
REQ-018 o_grant SHALL be one-hot or zero at all times.
REQ-019 Arbitration latency: IDLE request to first possible o_cts SHALL be exactly 1 cycle.

Reset
REQ-020 While rst_n is low at a clk edge, the block SHALL load:
- state = IDLE.
- rr_ptr = 0.
- stall count = 0.
- o_grant = 0.
- o_abort = 0.
REQ-021 Reset asserted mid-message SHALL drop the lock immediately with no o_abort pulse.
REQ-022 All combinational outputs SHALL read 0 during reset.

Structure
REQ-023 Shared package uart_pkg SHALL hold the arb_state_t enum (IDLE, LOCK, DRAIN) and the byte width constant 8.
REQ-024 Round-robin selection SHALL be one sub-module, rr_pick: inputs req vector and rr_ptr; outputs one-hot winner and any-valid flag; purely combinational.
REQ-025 Stall counter width SHALL be $clog2(TIMEOUT+1) bits.

Verification
REQ-026 Single requester: req[2] sends 7 bytes, last on the 7th, with tx_cts every cycle.
- grant = 4'b0100 one cycle after the request.
- 7 o_cts[2] pulses.
- DRAIN until tx_idle, then grant = 0 and rr_ptr = 3.
REQ-027 Contention: req[0] and req[3] both high from reset, rr_ptr = 0.
- Requester 0 served first.
- Requester 3 served next.
- Final rr_ptr = 0 (wrapped).
REQ-028 Timeout: TIMEOUT = 4; owner 1 sends 2 bytes, then drops req.
- o_abort pulses on the 4th stall cycle.
- grant = 0 on the next cycle.
- rr_ptr = 2.
REQ-029 Backpressure: tx_cts low for 10 cycles with req[0] held high.
- No o_cts pulses and no abort.
- Byte delivered unchanged once tx_cts rises.
REQ-030 Mid-message reset: assert rst_n = 0 during byte 3 of requester 1.
- All outputs 0 during reset.
- No o_abort pulse.
- Next arbitration starts at rr_ptr = 0.
REQ-031 Idle gating: tx_idle low while req[0] is high in IDLE.
- No grant is issued until tx_idle rises.
- Grant is issued one cycle after tx_idle rises.
